// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Purpose
//   Drives an N-digit multiplexed seven-segment display. Each 4-bit digit is
//   hex-decoded and the digits are scanned one at a time. Each digit is held
//   for REFRESH_DIV clocks. The segment lines are shared, and each digit has
//   its own enable line.
//
//   Display data is double-buffered:
//   - load writes value/dp_in/blank_in into a pending buffer.
//   - The pending buffer is copied into the active buffer only at a frame
//     boundary (the tick that ends the last digit), so a frame never mixes
//     old and new digits.
//   - If load coincides with a frame boundary, the inputs go straight into
//     the active buffer.
//
// Ports
//   clk         in   system clock
//   rst_n       in   synchronous reset, active low
//   value       in   4*NUM_DIGITS; digit i = value[4i+3:4i], digit 0 = LSD
//   dp_in       in   NUM_DIGITS decimal points, 1 = lit
//   blank_in    in   NUM_DIGITS force-dark flags (segments and dp), 1 = blank
//   load        in   single-cycle capture strobe for value/dp_in/blank_in
//   enable      in   0: display dark, prescaler and scan index frozen
//   seg_out     out  {a,b,c,d,e,f,g}, polarity per SEG_ACTIVE_LOW
//   dp_out      out  decimal point, polarity per SEG_ACTIVE_LOW
//   an_out      out  one-hot digit enables, polarity per AN_ACTIVE_LOW
//   digit_idx   out  index of the digit currently on seg_out/an_out
//   frame_done  out  one-cycle pulse following each frame boundary
//
// Handshake
//   load is a plain strobe with no ready: every cycle with load=1 is accepted
//   (last load wins), whether or not enable is high.
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS         = 4,
    parameter int REFRESH_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW     = 1'b1,
    parameter bit AN_ACTIVE_LOW      = 1'b1,
    parameter bit LEADING_ZERO_BLANK = 1'b1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic                    enable,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    // Register values that correspond to "everything off" at the pins.
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                              : {NUM_DIGITS{1'b0}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]          cnt_q,          cnt_d;
    logic [IDX_W-1:0]          idx_q,          idx_d;
    logic [4*NUM_DIGITS-1:0]   act_val_q,      act_val_d;
    logic [NUM_DIGITS-1:0]     act_dp_q,       act_dp_d;
    logic [NUM_DIGITS-1:0]     act_blank_q,    act_blank_d;
    logic [4*NUM_DIGITS-1:0]   pend_val_q,     pend_val_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q,      pend_dp_d;
    logic [NUM_DIGITS-1:0]     pend_blank_q,   pend_blank_d;
    logic                      pend_valid_q,   pend_valid_d;
    logic                      frame_done_q,   frame_done_d;
    logic [6:0]                seg_q,          seg_d;
    logic                      dp_q,           dp_d;
    logic [NUM_DIGITS-1:0]     an_q,           an_d;
    logic [IDX_W-1:0]          digit_idx_q,    digit_idx_d;

    // Scan timing
    logic tick;
    logic last_idx;
    logic frame_bound;

    // Per-digit combinational view
    logic [3:0]                cur_val;
    logic                      cur_dp;
    logic                      cur_blank;
    logic                      cur_lz;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic [NUM_DIGITS-1:0]     an_onehot;
    logic [6:0]                seg_lit;
    logic                      dp_lit;

    // ------------------------------------------------------------------
    // Hex to segment decode, 1 = lit, bit order {a,b,c,d,e,f,g}
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler and scan index
    // ------------------------------------------------------------------
    always_comb begin
        tick        = enable && (cnt_q == CNT_W'(REFRESH_DIV - 1));
        last_idx    = (idx_q == IDX_W'(NUM_DIGITS - 1));
        frame_bound = tick && last_idx;

        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        // A single-digit build always sees last_idx=1, so the index stays 0.
        idx_d = idx_q;
        if (tick) begin
            idx_d = last_idx ? '0 : idx_q + 1'b1;
        end

        frame_done_d = frame_bound;
    end

    // ------------------------------------------------------------------
    // Double buffer
    // ------------------------------------------------------------------
    always_comb begin
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;

        if (frame_bound && load) begin
            // A load on the boundary clock bypasses the pending buffer. Any
            // older pending data is superseded by this load, so it is dropped.
            act_val_d    = value;
            act_dp_d     = dp_in;
            act_blank_d  = blank_in;
            pend_valid_d = 1'b0;
        end else begin
            if (frame_bound && pend_valid_q) begin
                act_val_d    = pend_val_q;
                act_dp_d     = pend_dp_q;
                act_blank_d  = pend_blank_q;
                pend_valid_d = 1'b0;
            end
            if (load) begin
                pend_val_d   = value;
                pend_dp_d    = dp_in;
                pend_blank_d = blank_in;
                pend_valid_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask
    //   Digit i>0 is suppressed when it and every more significant digit
    //   are zero. Digit 0 is never suppressed, so a zero value shows "0".
    // ------------------------------------------------------------------
    always_comb begin
        logic run;
        lz_mask = '0;
        run     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run        = run && (act_val_q[4*i +: 4] == 4'h0);
            lz_mask[i] = run && LEADING_ZERO_BLANK;
        end
    end

    // ------------------------------------------------------------------
    // Current digit select and output stage next-state
    // ------------------------------------------------------------------
    always_comb begin
        cur_val   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        an_onehot = '0;
        // Compare-and-select avoids indexing past NUM_DIGITS when it is
        // not a power of two.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_val      = act_val_q[4*i +: 4];
                cur_dp       = act_dp_q[i];
                cur_blank    = act_blank_q[i];
                cur_lz       = lz_mask[i];
                an_onehot[i] = 1'b1;
            end
        end

        // Leading-zero blanking darkens segments only; blank_in also kills dp.
        seg_lit = hex_to_seg(cur_val);
        if (cur_blank || cur_lz) begin
            seg_lit = 7'h00;
        end
        dp_lit = cur_dp && !cur_blank;

        if (!enable) begin
            seg_lit   = 7'h00;
            dp_lit    = 1'b0;
            an_onehot = '0;
        end

        // Polarity is applied here so the registers hold pin-level values.
        seg_d       = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        dp_d        = SEG_ACTIVE_LOW ? ~dp_lit  : dp_lit;
        an_d        = AN_ACTIVE_LOW  ? ~an_onehot : an_onehot;
        digit_idx_d = idx_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            digit_idx_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            digit_idx_q  <= digit_idx_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign digit_idx  = digit_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Three instances share clock, reset, enable and load:
//   dut    : 4 digits, dwell 4 clocks, leading-zero blanking on
//   dut_nz : same, with leading-zero blanking off
//   dut_one: 1 digit, dwell 2 clocks
//
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge.
//
// Output timing (dwell 4, 4 digits):
//   - Let E be the boundary clock. frame_done is seen at the first falling
//     edge after E.
//   - Sample s after that (s = 1..16) shows digit (s-1)/4.
//   - The next frame_done is seen at s = 16.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic        enable;

    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx;
    logic        frame_done;

    logic [6:0]  nz_seg;
    logic        nz_dp;
    logic [3:0]  nz_an;
    logic [1:0]  nz_idx;
    logic        nz_fd;

    logic [6:0]  one_seg;
    logic        one_dp;
    logic [0:0]  one_an;
    logic [0:0]  one_idx;
    logic        one_fd;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
        .blank_in(blank_in), .load(load), .enable(enable),
        .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out),
        .digit_idx(digit_idx), .frame_done(frame_done)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4),
                            .LEADING_ZERO_BLANK(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
        .blank_in(blank_in), .load(load), .enable(enable),
        .seg_out(nz_seg), .dp_out(nz_dp), .an_out(nz_an),
        .digit_idx(nz_idx), .frame_done(nz_fd)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(2)) dut_one (
        .clk(clk), .rst_n(rst_n), .value(value[3:0]), .dp_in(dp_in[0:0]),
        .blank_in(blank_in[0:0]), .load(load), .enable(enable),
        .seg_out(one_seg), .dp_out(one_dp), .an_out(one_an),
        .digit_idx(one_idx), .frame_done(one_fd)
    );

    // Waits for frame_done on dut. n = number of falling edges waited.
    // n >= 200 means it timed out.
    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; enable = 1'b1;
        value = 16'h8888; dp_in = 4'hF; blank_in = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({an_out, seg_out, dp_out, digit_idx, frame_done} !== {4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset dut got an=%b seg=%b dp=%b idx=%0d fd=%b exp an=1111 seg=1111111 dp=1 idx=0 fd=0",
                     an_out, seg_out, dp_out, digit_idx, frame_done);
        end
        vec_cnt++;
        if ({nz_an, nz_seg, nz_dp, one_an, one_seg, one_dp, one_fd} !== {4'b1111, 7'h7F, 1'b1, 1'b1, 7'h7F, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset_others got nz_an=%b nz_seg=%b one_an=%b one_seg=%b one_fd=%b exp 1111 1111111 1 1111111 0",
                     nz_an, nz_seg, one_an, one_seg, one_fd);
        end
        rst_n = 1'b1; enable = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({an_out, seg_out, dp_out, frame_done} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset_disabled got an=%b seg=%b dp=%b fd=%b exp an=1111 seg=1111111 dp=1 fd=0",
                     an_out, seg_out, dp_out, frame_done);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_scan();
        logic [6:0] seg_exp [4];
        logic [3:0] an_exp;
        int n, k;
        seg_exp[0] = ~7'b1000111; seg_exp[1] = ~7'b1110111;
        seg_exp[2] = ~7'b1101101; seg_exp[3] = ~7'b0110000;
        @(negedge clk);
        value = 16'h12AF; dp_in = 4'h0; blank_in = 4'h0; load = 1'b1; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd(n);
        vec_cnt++;
        if (n >= 200) begin
            err_cnt++;
            $display("FAIL scan_wait frame_done not seen after %0d clks, required < 200", n);
        end
        for (int s = 1; s <= 16; s++) begin
            @(negedge clk);
            k = (s - 1) / 4;
            an_exp = 4'b0001 << k;
            an_exp = ~an_exp;
            vec_cnt++;
            if ({an_out, seg_out, dp_out, digit_idx, frame_done} !==
                {an_exp, seg_exp[k], 1'b1, 2'(k), (s == 16)}) begin
                err_cnt++;
                $display("FAIL scan s=%0d got an=%b seg=%b dp=%b idx=%0d fd=%b exp an=%b seg=%b dp=1 idx=%0d fd=%b",
                         s, an_out, seg_out, dp_out, digit_idx, frame_done, an_exp, seg_exp[k], k, (s == 16));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_no_tearing();
        logic [6:0] old_exp [4];
        logic [6:0] new_exp [4];
        logic [3:0] an_exp;
        int n, k;
        old_exp[0] = ~7'b1000111; old_exp[1] = ~7'b1110111;
        old_exp[2] = ~7'b1101101; old_exp[3] = ~7'b0110000;
        new_exp[0] = ~7'b1111111; new_exp[1] = ~7'b1110000;
        new_exp[2] = ~7'b1011111; new_exp[3] = ~7'b1011011;
        wait_fd(n);
        vec_cnt++;
        if (n >= 200) begin
            err_cnt++;
            $display("FAIL tear_wait frame_done not seen after %0d clks, required < 200", n);
        end
        for (int s = 1; s <= 32; s++) begin
            @(negedge clk);
            k = ((s - 1) % 16) / 4;
            an_exp = 4'b0001 << k;
            an_exp = ~an_exp;
            vec_cnt++;
            if ({an_out, seg_out, frame_done} !==
                {an_exp, (s <= 16) ? old_exp[k] : new_exp[k], (s == 16 || s == 32)}) begin
                err_cnt++;
                $display("FAIL tear s=%0d got an=%b seg=%b fd=%b exp an=%b seg=%b fd=%b",
                         s, an_out, seg_out, frame_done, an_exp,
                         (s <= 16) ? old_exp[k] : new_exp[k], (s == 16 || s == 32));
            end
            if (s == 1) begin value = 16'h0000; load = 1'b1; end
            if (s == 2) load = 1'b0;
            if (s == 6) begin value = 16'h5678; load = 1'b1; end
            if (s == 7) load = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_leading_zero();
        logic [6:0] seg_exp [4];
        logic [6:0] nz_exp [4];
        logic       dp_exp [4];
        logic [3:0] an_exp;
        int n, k;
        seg_exp[0] = ~7'b1111110; seg_exp[1] = ~7'b1110000; seg_exp[2] = 7'h7F; seg_exp[3] = 7'h7F;
        nz_exp[0]  = ~7'b1111110; nz_exp[1]  = ~7'b1110000;
        nz_exp[2]  = ~7'b1111110; nz_exp[3]  = ~7'b1111110;
        dp_exp[0] = 1'b1; dp_exp[1] = 1'b1; dp_exp[2] = 1'b0; dp_exp[3] = 1'b1;
        @(negedge clk);
        value = 16'h0070; dp_in = 4'b0100; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd(n);
        vec_cnt++;
        if (n >= 200) begin
            err_cnt++;
            $display("FAIL lz_wait frame_done not seen after %0d clks, required < 200", n);
        end
        for (int s = 1; s <= 16; s++) begin
            @(negedge clk);
            k = (s - 1) / 4;
            an_exp = 4'b0001 << k;
            an_exp = ~an_exp;
            vec_cnt++;
            if ({an_out, seg_out, dp_out, nz_seg, nz_dp} !==
                {an_exp, seg_exp[k], dp_exp[k], nz_exp[k], dp_exp[k]}) begin
                err_cnt++;
                $display("FAIL lz s=%0d got an=%b seg=%b dp=%b nz_seg=%b nz_dp=%b exp an=%b seg=%b dp=%b nz_seg=%b nz_dp=%b",
                         s, an_out, seg_out, dp_out, nz_seg, nz_dp,
                         an_exp, seg_exp[k], dp_exp[k], nz_exp[k], dp_exp[k]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_enable_blank();
        logic [6:0] seg_exp [4];
        logic       dp_exp [4];
        logic [3:0] an_exp;
        int n, k;
        seg_exp[0] = 7'h7F; seg_exp[1] = ~7'b1110000; seg_exp[2] = 7'h7F; seg_exp[3] = 7'h7F;
        dp_exp[0] = 1'b1; dp_exp[1] = 1'b1; dp_exp[2] = 1'b0; dp_exp[3] = 1'b1;
        wait_fd(n);
        vec_cnt++;
        if (n >= 200) begin
            err_cnt++;
            $display("FAIL en_wait frame_done not seen after %0d clks, required < 200", n);
        end
        // Index and count were just reset to 0 by the boundary. They must
        // stay there while disabled.
        enable = 1'b0;
        for (int s = 1; s <= 10; s++) begin
            @(negedge clk);
            vec_cnt++;
            if ({an_out, seg_out, dp_out, digit_idx, frame_done} !== {4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
                err_cnt++;
                $display("FAIL disabled s=%0d got an=%b seg=%b dp=%b idx=%0d fd=%b exp an=1111 seg=1111111 dp=1 idx=0 fd=0",
                         s, an_out, seg_out, dp_out, digit_idx, frame_done);
            end
        end
        enable = 1'b1; blank_in = 4'b0001; dp_in = 4'b0101; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        vec_cnt++;
        if ({an_out, seg_out, dp_out, digit_idx} !== {4'b1110, ~7'b1111110, 1'b1, 2'd0}) begin
            err_cnt++;
            $display("FAIL resume got an=%b seg=%b dp=%b idx=%0d exp an=1110 seg=0000001 dp=1 idx=0",
                     an_out, seg_out, dp_out, digit_idx);
        end
        wait_fd(n);
        vec_cnt++;
        if (n != 15) begin
            err_cnt++;
            $display("FAIL resume_frame_len got %0d clks exp 15", n);
        end
        for (int s = 1; s <= 16; s++) begin
            @(negedge clk);
            k = (s - 1) / 4;
            an_exp = 4'b0001 << k;
            an_exp = ~an_exp;
            vec_cnt++;
            if ({an_out, seg_out, dp_out} !== {an_exp, seg_exp[k], dp_exp[k]}) begin
                err_cnt++;
                $display("FAIL blank s=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                         s, an_out, seg_out, dp_out, an_exp, seg_exp[k], dp_exp[k]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_boundary_collision();
        logic [6:0] seg_exp [4];
        logic [3:0] an_exp;
        int n, k;
        seg_exp[0] = ~7'b1000111; seg_exp[1] = ~7'b1001111;
        seg_exp[2] = ~7'b1001111; seg_exp[3] = ~7'b0011111;
        blank_in = 4'h0; dp_in = 4'h0;
        wait_fd(n);
        vec_cnt++;
        if (n >= 200) begin
            err_cnt++;
            $display("FAIL coll_wait frame_done not seen after %0d clks, required < 200", n);
        end
        for (int s = 1; s <= 15; s++) begin
            @(negedge clk);
            load = 1'b0;
            if (s == 3)  begin value = 16'h3333; load = 1'b1; end
            if (s == 15) begin value = 16'hBEEF; load = 1'b1; end
        end
        @(negedge clk);
        load = 1'b0;
        vec_cnt++;
        if (frame_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL coll_boundary got fd=%b exp fd=1", frame_done);
        end
        for (int s = 1; s <= 32; s++) begin
            @(negedge clk);
            k = ((s - 1) % 16) / 4;
            an_exp = 4'b0001 << k;
            an_exp = ~an_exp;
            vec_cnt++;
            if ({an_out, seg_out, dp_out, frame_done} !==
                {an_exp, seg_exp[k], 1'b1, (s == 16 || s == 32)}) begin
                err_cnt++;
                $display("FAIL coll s=%0d got an=%b seg=%b dp=%b fd=%b exp an=%b seg=%b dp=1 fd=%b",
                         s, an_out, seg_out, dp_out, frame_done, an_exp, seg_exp[k], (s == 16 || s == 32));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_digit();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (one_fd !== 1'b1 && n < 10);
        vec_cnt++;
        if (n >= 10) begin
            err_cnt++;
            $display("FAIL one_wait frame_done not seen after %0d clks, required < 10", n);
        end
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            vec_cnt++;
            if ({one_an, one_idx, one_seg, one_dp, one_fd} !==
                {1'b0, 1'b0, ~7'b1000111, 1'b1, (s % 2 == 0)}) begin
                err_cnt++;
                $display("FAIL one s=%0d got an=%b idx=%0d seg=%b dp=%b fd=%b exp an=0 idx=0 seg=0111000 dp=1 fd=%b",
                         s, one_an, one_idx, one_seg, one_dp, one_fd, (s % 2 == 0));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_abort();
        logic [3:0] an_exp;
        int n, k;
        @(negedge clk);
        value = 16'h4321; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vec_cnt++;
        if ({an_out, seg_out, dp_out, digit_idx, frame_done} !== {4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL abort_reset got an=%b seg=%b dp=%b idx=%0d fd=%b exp an=1111 seg=1111111 dp=1 idx=0 fd=0",
                     an_out, seg_out, dp_out, digit_idx, frame_done);
        end
        wait_fd(n);
        vec_cnt++;
        if (n != 16) begin
            err_cnt++;
            $display("FAIL abort_frame_len got %0d clks exp 16", n);
        end
        // Pending 4321 was discarded, so the display shows a lone "0".
        for (int s = 1; s <= 16; s++) begin
            @(negedge clk);
            k = (s - 1) / 4;
            an_exp = 4'b0001 << k;
            an_exp = ~an_exp;
            vec_cnt++;
            if ({an_out, seg_out, dp_out} !== {an_exp, (k == 0) ? ~7'b1111110 : 7'h7F, 1'b1}) begin
                err_cnt++;
                $display("FAIL abort s=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=1",
                         s, an_out, seg_out, dp_out, an_exp, (k == 0) ? ~7'b1111110 : 7'h7F);
            end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_scan();
        test_no_tearing();
        test_leading_zero();
        test_enable_blank();
        test_boundary_collision();
        test_single_digit();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
